// File: rtl/onchip_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : onchip_ram_arbiter
// Brief   : Round-robin arbiter sharing a single-port on-chip RAM between two
//           Avalon-MM requesters, with optional zero-fill after reset.
// Revision: 1.0 - initial release
// ============================================================================
module onchip_ram_arbiter #(
    parameter int ADDR_W         = 12,
    parameter int DATA_W         = 32,
    parameter int BE_W           = 4,
    parameter int RD_LATENCY     = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] ram_address,
    output logic [BE_W-1:0]   ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              ram_clken,
    input  logic [DATA_W-1:0] ram_readdata,
    output logic              init_done
);

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] C_LAST_ADDR   = {ADDR_W{1'b1}};
    localparam state_t            C_RESET_STATE = CLEAR_ON_RESET ? S_INIT : S_RUN;

    state_t                r_state_q, w_state_d;
    logic [ADDR_W-1:0]     r_init_cnt_q, w_init_cnt_d;
    logic                  r_rr_q, w_rr_d;          // 1 = m1 preferred on contention
    logic [RD_LATENCY-1:0] r_tag_vld_q, w_tag_vld_d;
    logic [RD_LATENCY-1:0] r_tag_id_q, w_tag_id_d;

    logic w_req0, w_req1, w_gnt0, w_gnt1, w_rd_push;
    logic w_wait0, w_wait1, w_cs, w_wr;

    assign w_req0 = m0_read | m0_write;
    assign w_req1 = m1_read | m1_write;

    always_comb begin
        w_state_d    = r_state_q;
        w_init_cnt_d = r_init_cnt_q;
        w_rr_d       = r_rr_q;
        w_gnt0       = 1'b0;
        w_gnt1       = 1'b0;
        w_wait0      = 1'b1;
        w_wait1      = 1'b1;
        w_cs         = 1'b0;
        w_wr         = 1'b0;
        ram_address    = '0;
        ram_byteenable = '0;
        ram_writedata  = '0;

        case (r_state_q)
            S_INIT: begin
                w_cs           = 1'b1;
                w_wr           = 1'b1;
                ram_address    = r_init_cnt_q;
                ram_byteenable = {BE_W{1'b1}};
                if (r_init_cnt_q == C_LAST_ADDR) begin
                    w_state_d = S_RUN;
                end else begin
                    w_init_cnt_d = r_init_cnt_q + 1'b1;
                end
            end
            default: begin
                w_gnt0 = w_req0 & (~w_req1 | ~r_rr_q);
                w_gnt1 = w_req1 & (~w_req0 |  r_rr_q);
                if (w_gnt0) begin
                    w_wait0        = 1'b0;
                    w_cs           = 1'b1;
                    w_wr           = m0_write;
                    ram_address    = m0_address;
                    ram_byteenable = m0_byteenable;
                    ram_writedata  = m0_writedata;
                    w_rr_d         = 1'b1;
                end else if (w_gnt1) begin
                    w_wait1        = 1'b0;
                    w_cs           = 1'b1;
                    w_wr           = m1_write;
                    ram_address    = m1_address;
                    ram_byteenable = m1_byteenable;
                    ram_writedata  = m1_writedata;
                    w_rr_d         = 1'b0;
                end
            end
        endcase
    end

    // A read that also carries a write is treated as a write: no return tag.
    assign w_rd_push = (w_gnt0 & m0_read & ~m0_write) | (w_gnt1 & m1_read & ~m1_write);

    always_comb begin
        w_tag_vld_d    = r_tag_vld_q;
        w_tag_id_d     = r_tag_id_q;
        w_tag_vld_d[0] = w_rd_push;
        w_tag_id_d[0]  = w_gnt1;
        for (int i = 1; i < RD_LATENCY; i++) begin
            w_tag_vld_d[i] = r_tag_vld_q[i-1];
            w_tag_id_d[i]  = r_tag_id_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q    <= C_RESET_STATE;
            r_init_cnt_q <= '0;
            r_rr_q       <= 1'b0;
            r_tag_vld_q  <= '0;
            r_tag_id_q   <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_init_cnt_q <= w_init_cnt_d;
            r_rr_q       <= w_rr_d;
            r_tag_vld_q  <= w_tag_vld_d;
            r_tag_id_q   <= w_tag_id_d;
        end
    end

    // Reset holds every handshake output in its idle state, independent of FSM state.
    assign m0_waitrequest   = w_wait0 | reset;
    assign m1_waitrequest   = w_wait1 | reset;
    assign ram_chipselect   = w_cs & ~reset;
    assign ram_write        = w_wr & ~reset;
    assign ram_clken        = 1'b1;
    assign init_done        = (r_state_q == S_RUN) & ~reset;
    assign m0_readdata      = ram_readdata;
    assign m1_readdata      = ram_readdata;
    assign m0_readdatavalid = r_tag_vld_q[RD_LATENCY-1] & ~r_tag_id_q[RD_LATENCY-1] & ~reset;
    assign m1_readdatavalid = r_tag_vld_q[RD_LATENCY-1] &  r_tag_id_q[RD_LATENCY-1] & ~reset;

endmodule
`default_nettype wire
